bar0_cq_completer: RTL and testbench
====================================

Name: bar0_cq_completer

Overview:
- Consumes the parsed Completer reQuest descriptor stream and executes BAR0 register writes and reads against a simple register-file port.
- Generates Completer Completion (CC) TLPs on the 256-bit AXI-Stream CC interface for reads.
- The CQ side has no backpressure (cq_valid is one beat per request, always accepted), so reads are buffered in a small FIFO. Completions are issued one at a time under CC tready flow control.

Parameters:
- DATA_WIDTH, 256, CC AXI-Stream data width (only 256 supported)
- BAR0_SIZE, 16, byte address width of BAR0
- BAR_ID, 0, cq_bar_id value this block serves
- RD_FIFO_DEPTH, 4, pending read entries (power of 2)
- RD_TIMEOUT, 255, max cycles waiting for reg_rd_data_valid

Ports:
- user_clk  in  1  clock
- user_reset_n  in  1  async active-low reset
- cq_valid  in  1  descriptor valid, single cycle per request
- cq_type  in  4  4'b0000 mem read, 4'b0001 mem write
- cq_reg_addr  in  BAR0_SIZE  DW-aligned byte address
- cq_wr_data  in  64  write payload {DW1,DW0}
- cq_bar_id  in  3  target BAR
- cq_requester_id  in  16  requester ID
- cq_tag  in  8  tag
- cq_tc  in  3  traffic class
- cq_lower_addr  in  7  lower address for completion
- cq_dword_count  in  11  request length in DW
- reg_wr_en  out  1  one-cycle write strobe
- reg_wr_addr  out  BAR0_SIZE  write address
- reg_wr_data  out  64  write data
- reg_wr_wide  out  1  1=64-bit write, 0=low 32 bits only
- reg_rd_en  out  1  one-cycle read strobe
- reg_rd_addr  out  BAR0_SIZE  read address
- reg_rd_data  in  64  read data
- reg_rd_data_valid  in  1  read data valid
- s_axis_cc_tdata  out  256  CC descriptor+payload
- s_axis_cc_tkeep  out  8  DW keep
- s_axis_cc_tlast  out  1  always 1 when tvalid
- s_axis_cc_tvalid  out  1  completion valid
- s_axis_cc_tuser  out  33  tied 0
- s_axis_cc_tready  in  1  sink ready
- rd_overflow  out  1  sticky: read dropped, FIFO full
- unsupported_cnt  out  16  saturating count of ignored requests

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, FIFO empty, counters 0. Reset mid-completion drops tvalid immediately; that completion is lost.
- Decode uses the cycle-of-cq_valid fields only; nothing is registered from the CQ side except what is listed below.
- Write path (cq_valid, type 0001, bar==BAR_ID, dword_count 1 or 2):
  - reg_wr_en pulses exactly 1 cycle, on the cycle after cq_valid.
  - addr and data are registered alongside it; reg_wr_wide = (dword_count==2).
  - No completion is generated (posted write).
- Write with dword_count 0 or >2: dropped; unsupported_cnt increments.
- Read path (cq_valid, type 0000, bar==BAR_ID): push {addr, requester_id, tag, tc, lower_addr, dw_cnt, ur} into the FIFO.
  - ur=1 when dword_count is not 1 or 2.
- Any other type or BAR mismatch: ignored; unsupported_cnt increments and saturates at 16'hFFFF.
- FIFO push condition: count<DEPTH, or a pop occurs in the same cycle.
  - Otherwise the read is dropped and rd_overflow sets (cleared only by reset).
  - Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: FIFO non-empty → pop head. ur=0 goes to RD_REQ; ur=1 goes to CC_SEND with UR status.
  - RD_REQ: reg_rd_en=1 for one cycle, reg_rd_addr=entry addr; → RD_WAIT.
  - RD_WAIT: on reg_rd_data_valid capture data → CC_SEND. If RD_TIMEOUT cycles elapse first, data=64'hFFFF_FFFF_FFFF_FFFF → CC_SEND.
  - CC_SEND: tvalid=1 with tdata/tkeep held stable until tready; on tvalid&tready → IDLE. Minimum one idle cycle between completions.
- CC descriptor fields:
  - [6:0] lower_addr
  - [28:16] byte count = dw_cnt*4 (UR: 4)
  - [42:32] dword count = dw_cnt (UR: 0)
  - [45:43] status: 000 SC, 001 UR
  - [63:48] requester_id
  - [71:64] tag
  - [88] completer ID enable = 0
  - [91:89] tc
  - all other descriptor bits 0
- CC payload and keep:
  - Payload DW0 at [127:96], DW1 at [159:128].
  - tkeep: 8'h0F for 1 DW, 8'h1F for 2 DW, 8'h07 for UR.
  - Unused tdata bits = 0.
- Write and read strobes may assert in the same cycle (independent paths).

Test Plan:
- Write, bar 0, addr 16'h0010, dw_cnt 2, data 64'h1122_3344_5566_7788 → next cycle reg_wr_en=1, addr 16'h0010, reg_wr_wide=1, no CC traffic.
- Read addr 16'h0020, tag 8'h05, dw_cnt 2, reg_rd_data 64'hAABB_CCDD_0011_2233 valid 3 cycles after strobe, tready=1 → one CC beat: dword count 2, byte count 8, tag 05, [127:96]=0011_2233, [159:128]=AABB_CCDD, tkeep 8'h1F.
- Five back-to-back reads, tready=0 throughout → first four accepted, fifth drops, rd_overflow=1. Release tready → four completions emitted in tag order.
- Read with dw_cnt 4 → UR completion: status 001, dword count 0, byte count 4, tkeep 8'h07, no reg_rd_en pulse.
- Read, reg_rd_data_valid never asserts → after 255 cycles a completion goes out with both DWs 32'hFFFF_FFFF, status SC.
- Reset asserted while tvalid held with tready=0 → tvalid=0 asynchronously, FIFO empty, counters 0.

Source files
------------

// File: rtl/bar0_cq_completer.sv
// BAR0 completer: executes CQ register writes/reads against a simple register port
// and returns read completions on the 256-bit CC AXI-Stream interface.
module bar0_cq_completer #(
  parameter int DATA_WIDTH    = 256,
  parameter int BAR0_SIZE     = 16,
  parameter int BAR_ID        = 0,
  parameter int RD_FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT    = 255
) (
  input  logic                  user_clk,
  input  logic                  user_reset_n,
  input  logic                  cq_valid,
  input  logic [3:0]            cq_type,
  input  logic [BAR0_SIZE-1:0]  cq_reg_addr,
  input  logic [63:0]           cq_wr_data,
  input  logic [2:0]            cq_bar_id,
  input  logic [15:0]           cq_requester_id,
  input  logic [7:0]            cq_tag,
  input  logic [2:0]            cq_tc,
  input  logic [6:0]            cq_lower_addr,
  input  logic [10:0]           cq_dword_count,
  output logic                  reg_wr_en,
  output logic [BAR0_SIZE-1:0]  reg_wr_addr,
  output logic [63:0]           reg_wr_data,
  output logic                  reg_wr_wide,
  output logic                  reg_rd_en,
  output logic [BAR0_SIZE-1:0]  reg_rd_addr,
  input  logic [63:0]           reg_rd_data,
  input  logic                  reg_rd_data_valid,
  output logic [DATA_WIDTH-1:0] s_axis_cc_tdata,
  output logic [7:0]            s_axis_cc_tkeep,
  output logic                  s_axis_cc_tlast,
  output logic                  s_axis_cc_tvalid,
  output logic [32:0]           s_axis_cc_tuser,
  input  logic                  s_axis_cc_tready,
  output logic                  rd_overflow,
  output logic [15:0]           unsupported_cnt
);

  // RD_FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally
  localparam int PTR_W = (RD_FIFO_DEPTH > 1) ? $clog2(RD_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(RD_TIMEOUT + 1);

  typedef struct packed {
    logic [BAR0_SIZE-1:0] addr;
    logic [15:0]          req_id;
    logic [7:0]           tag;
    logic [2:0]           tc;
    logic [6:0]           lower_addr;
    logic [10:0]          dw_cnt;
    logic                 ur;
  } rd_entry_t;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, CC_SEND} state_e;

  state_e                state_q, state_d;
  rd_entry_t             fifo_q [RD_FIFO_DEPTH];
  rd_entry_t             fifo_d [RD_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  rd_entry_t             cur_q, cur_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  wr_en_q, wr_en_d, wr_wide_q, wr_wide_d;
  logic [BAR0_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [63:0]           wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [7:0]            tkeep_q, tkeep_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           unsup_q, unsup_d;

  logic      bar_hit, dw_ok, wr_ok, rd_req, unsup, push, pop;
  rd_entry_t head, new_entry;

  assign bar_hit = (cq_bar_id == 3'(BAR_ID));
  assign dw_ok   = (cq_dword_count == 11'd1) || (cq_dword_count == 11'd2);
  assign wr_ok   = cq_valid && bar_hit && (cq_type == 4'b0001) && dw_ok;
  assign rd_req  = cq_valid && bar_hit && (cq_type == 4'b0000);
  assign unsup   = cq_valid && !wr_ok && !rd_req;
  assign head    = fifo_q[rd_ptr_q];

  always_comb begin
    new_entry            = '0;
    new_entry.addr       = cq_reg_addr;
    new_entry.req_id     = cq_requester_id;
    new_entry.tag        = cq_tag;
    new_entry.tc         = cq_tc;
    new_entry.lower_addr = cq_lower_addr;
    new_entry.dw_cnt     = cq_dword_count;
    new_entry.ur         = !dw_ok;
  end

  function automatic logic [DATA_WIDTH-1:0] build_cc(input rd_entry_t e, input logic [63:0] d);
    logic [DATA_WIDTH-1:0] t;
    t          = '0;
    t[6:0]     = e.lower_addr;
    t[63:48]   = e.req_id;
    t[71:64]   = e.tag;
    t[91:89]   = e.tc;
    if (e.ur) begin
      t[28:16] = 13'd4;
      t[45:43] = 3'b001;
    end else begin
      t[28:16]   = {e.dw_cnt, 2'b00};
      t[42:32]   = e.dw_cnt;
      t[127:96]  = d[31:0];
      if (e.dw_cnt == 11'd2) t[159:128] = d[63:32];
    end
    return t;
  endfunction

  function automatic logic [7:0] cc_keep(input rd_entry_t e);
    if (e.ur) return 8'h07;
    return (e.dw_cnt == 11'd2) ? 8'h1F : 8'h0F;
  endfunction

  always_comb begin
    state_d    = state_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cur_d      = cur_q;
    to_cnt_d   = to_cnt_q;
    wr_en_d    = wr_ok;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_wide_d  = wr_wide_q;
    rd_en_d    = 1'b0;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    tkeep_d    = tkeep_q;
    overflow_d = overflow_q;
    unsup_d    = unsup_q;
    pop        = 1'b0;

    if (wr_ok) begin
      wr_addr_d = cq_reg_addr;
      wr_data_d = cq_wr_data;
      wr_wide_d = (cq_dword_count == 11'd2);
    end
    if (unsup && (unsup_q != '1)) unsup_d = unsup_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          cur_d = head;
          if (head.ur) begin
            tvalid_d = 1'b1;
            tdata_d  = build_cc(head, '0);
            tkeep_d  = cc_keep(head);
            state_d  = CC_SEND;
          end else begin
            rd_en_d = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        to_cnt_d = '0;
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        if (reg_rd_data_valid || (to_cnt_q == TO_W'(RD_TIMEOUT - 1))) begin
          tvalid_d = 1'b1;
          tdata_d  = build_cc(cur_q, reg_rd_data_valid ? reg_rd_data : '1);
          tkeep_d  = cc_keep(cur_q);
          state_d  = CC_SEND;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CC_SEND: begin
        if (s_axis_cc_tready) begin
          tvalid_d = 1'b0;
          tdata_d  = '0;
          tkeep_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO still accepts a push when the head leaves in the same cycle
    push = rd_req && ((count_q < CNT_W'(RD_FIFO_DEPTH)) || pop);
    if (rd_req && !push) overflow_d = 1'b1;
    if (push) begin
      fifo_d[wr_ptr_q] = new_entry;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q    <= IDLE;
      for (int unsigned i = 0; i < RD_FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cur_q      <= '0;
      to_cnt_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_wide_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      tkeep_q    <= '0;
      overflow_q <= 1'b0;
      unsup_q    <= '0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cur_q      <= cur_d;
      to_cnt_q   <= to_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_wide_q  <= wr_wide_d;
      rd_en_q    <= rd_en_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      overflow_q <= overflow_d;
      unsup_q    <= unsup_d;
    end
  end

  assign reg_wr_en        = wr_en_q;
  assign reg_wr_addr      = wr_addr_q;
  assign reg_wr_data      = wr_data_q;
  assign reg_wr_wide      = wr_wide_q;
  assign reg_rd_en        = rd_en_q;
  assign reg_rd_addr      = cur_q.addr;
  assign s_axis_cc_tdata  = tdata_q;
  assign s_axis_cc_tkeep  = tkeep_q;
  assign s_axis_cc_tlast  = tvalid_q;
  assign s_axis_cc_tvalid = tvalid_q;
  assign s_axis_cc_tuser  = '0;
  assign rd_overflow      = overflow_q;
  assign unsupported_cnt  = unsup_q;

endmodule

// File: tb/tb_bar0_cq_completer.sv
// Directed bench for bar0_cq_completer: register writes, reads, UR, overflow,
// read timeout and asynchronous reset during a stalled completion.
module tb_bar0_cq_completer;

  logic         user_clk = 1'b0;
  logic         user_reset_n = 1'b0;
  logic         cq_valid = 1'b0;
  logic [3:0]   cq_type = '0;
  logic [15:0]  cq_reg_addr = '0;
  logic [63:0]  cq_wr_data = '0;
  logic [2:0]   cq_bar_id = '0;
  logic [15:0]  cq_requester_id = '0;
  logic [7:0]   cq_tag = '0;
  logic [2:0]   cq_tc = '0;
  logic [6:0]   cq_lower_addr = '0;
  logic [10:0]  cq_dword_count = '0;
  logic         reg_wr_en, reg_wr_wide, reg_rd_en;
  logic [15:0]  reg_wr_addr, reg_rd_addr;
  logic [63:0]  reg_wr_data;
  logic [63:0]  reg_rd_data = '0;
  logic         reg_rd_data_valid = 1'b0;
  logic [255:0] s_axis_cc_tdata;
  logic [7:0]   s_axis_cc_tkeep;
  logic         s_axis_cc_tlast, s_axis_cc_tvalid;
  logic [32:0]  s_axis_cc_tuser;
  logic         s_axis_cc_tready = 1'b0;
  logic         rd_overflow;
  logic [15:0]  unsupported_cnt;

  bar0_cq_completer #(
    .DATA_WIDTH(256), .BAR0_SIZE(16), .BAR_ID(0), .RD_FIFO_DEPTH(4), .RD_TIMEOUT(255)
  ) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n),
    .cq_valid(cq_valid), .cq_type(cq_type), .cq_reg_addr(cq_reg_addr),
    .cq_wr_data(cq_wr_data), .cq_bar_id(cq_bar_id), .cq_requester_id(cq_requester_id),
    .cq_tag(cq_tag), .cq_tc(cq_tc), .cq_lower_addr(cq_lower_addr),
    .cq_dword_count(cq_dword_count),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_wide(reg_wr_wide), .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .reg_rd_data_valid(reg_rd_data_valid),
    .s_axis_cc_tdata(s_axis_cc_tdata), .s_axis_cc_tkeep(s_axis_cc_tkeep),
    .s_axis_cc_tlast(s_axis_cc_tlast), .s_axis_cc_tvalid(s_axis_cc_tvalid),
    .s_axis_cc_tuser(s_axis_cc_tuser), .s_axis_cc_tready(s_axis_cc_tready),
    .rd_overflow(rd_overflow), .unsupported_cnt(unsupported_cnt)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_en_cnt = 0, wr_en_cnt = 0, b2b_cnt = 0;
  int rd_en_cyc = 0;
  logic [15:0] last_rd_addr = '0;
  logic hs_prev = 1'b0;
  logic [255:0] beat_data[$];
  logic [7:0]   beat_keep[$];
  logic         beat_last[$];
  int           beat_cyc[$];
  int  rd_lat = 3;
  logic rd_resp_en = 1'b1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge user_clk) cyc++;

  always @(negedge user_clk) begin
    if (reg_rd_en) begin
      rd_en_cnt++;
      rd_en_cyc    = cyc;
      last_rd_addr = reg_rd_addr;
    end
    if (reg_wr_en) wr_en_cnt++;
    if (s_axis_cc_tvalid && hs_prev) b2b_cnt++;
    hs_prev = s_axis_cc_tvalid && s_axis_cc_tready;
    if (s_axis_cc_tvalid && s_axis_cc_tready) begin
      beat_data.push_back(s_axis_cc_tdata);
      beat_keep.push_back(s_axis_cc_tkeep);
      beat_last.push_back(s_axis_cc_tlast);
      beat_cyc.push_back(cyc);
    end
  end

  // Register-file read responder with programmable latency
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge user_clk);
      if (reg_rd_en && rd_resp_en) begin
        a = reg_rd_addr;
        repeat (rd_lat) @(posedge user_clk);
        #1;
        reg_rd_data_valid = 1'b1;
        reg_rd_data = (a == 16'h0020) ? 64'hAABB_CCDD_0011_2233 : {16'hDA7A, a, 16'h5EED, a};
        @(posedge user_clk);
        #1;
        reg_rd_data_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic cq_req(input logic [3:0] typ, input logic [15:0] addr, input logic [63:0] data,
                        input logic [2:0] bar, input logic [15:0] rid, input logic [7:0] tag,
                        input logic [2:0] tc, input logic [6:0] la, input logic [10:0] dw);
    cq_valid = 1'b1; cq_type = typ; cq_reg_addr = addr; cq_wr_data = data; cq_bar_id = bar;
    cq_requester_id = rid; cq_tag = tag; cq_tc = tc; cq_lower_addr = la; cq_dword_count = dw;
    tick();
    cq_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (beat_data.size() < n && k < budget) begin
      @(negedge user_clk);
      k++;
    end
    check(tag, 256'(beat_data.size() >= n), 256'(1));
  endtask

  task automatic clear_beats();
    beat_data.delete(); beat_keep.delete(); beat_last.delete(); beat_cyc.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] b;
    logic [7:0]   exp_tags [6];
    logic [15:0]  exp_addr [6];
    int rd_en0, k;

    // Reset state
    @(posedge user_clk);
    @(negedge user_clk);
    check("rst_tvalid", 256'(s_axis_cc_tvalid), 256'(0));
    check("rst_tdata", s_axis_cc_tdata, 256'(0));
    check("rst_wr_en", 256'(reg_wr_en), 256'(0));
    check("rst_rd_en", 256'(reg_rd_en), 256'(0));
    check("rst_unsup", 256'(unsupported_cnt), 256'(0));
    check("rst_ovf", 256'(rd_overflow), 256'(0));
    check("rst_tuser", 256'(s_axis_cc_tuser), 256'(0));
    repeat (2) @(posedge user_clk);
    #1 user_reset_n = 1'b1;
    s_axis_cc_tready = 1'b1;
    tick();

    // Writes: wide, narrow, then four unsupported requests
    cq_req(4'b0001, 16'h0010, 64'h1122_3344_5566_7788, 3'd0, 16'h0100, 8'h00, 3'd0, 7'h10, 11'd2);
    @(negedge user_clk);
    check("wr_en", 256'(reg_wr_en), 256'(1));
    check("wr_addr", 256'(reg_wr_addr), 256'(16'h0010));
    check("wr_data", 256'(reg_wr_data), 256'(64'h1122_3344_5566_7788));
    check("wr_wide", 256'(reg_wr_wide), 256'(1));
    @(negedge user_clk);
    check("wr_en_pulse", 256'(reg_wr_en), 256'(0));
    tick();
    cq_req(4'b0001, 16'h0014, 64'hCAFE_0000_DEAD_BEEF, 3'd0, 16'h0100, 8'h00, 3'd0, 7'h14, 11'd1);
    @(negedge user_clk);
    check("wr_narrow_en", 256'(reg_wr_en), 256'(1));
    check("wr_narrow_wide", 256'(reg_wr_wide), 256'(0));
    check("wr_narrow_addr", 256'(reg_wr_addr), 256'(16'h0014));
    tick();
    cq_req(4'b0001, 16'h0018, 64'h1, 3'd0, 16'h0100, 8'h00, 3'd0, 7'h18, 11'd3);
    cq_req(4'b0001, 16'h0018, 64'h2, 3'd1, 16'h0100, 8'h00, 3'd0, 7'h18, 11'd1);
    cq_req(4'b0010, 16'h0018, 64'h3, 3'd0, 16'h0100, 8'h00, 3'd0, 7'h18, 11'd1);
    cq_req(4'b0001, 16'h0018, 64'h4, 3'd0, 16'h0100, 8'h00, 3'd0, 7'h18, 11'd0);
    repeat (4) @(negedge user_clk);
    check("unsup_cnt", 256'(unsupported_cnt), 256'(4));
    check("wr_pulses", 256'(wr_en_cnt), 256'(2));
    check("wr_no_cc", 256'(beat_data.size()), 256'(0));
    check("wr_no_rd", 256'(rd_en_cnt), 256'(0));

    // Two-DW read, data valid three cycles after the strobe
    rd_lat = 3;
    tick();
    cq_req(4'b0000, 16'h0020, 64'h0, 3'd0, 16'hABCD, 8'h05, 3'd2, 7'h20, 11'd2);
    wait_beats(1, 50, "rd2_wait");
    check("rd2_tdata", beat_data[0],
          {96'h0, 32'hAABB_CCDD, 32'h0011_2233, 32'h0400_0005, 32'hABCD_0002, 32'h0008_0020});
    check("rd2_tkeep", 256'(beat_keep[0]), 256'(8'h1F));
    check("rd2_tlast", 256'(beat_last[0]), 256'(1));
    check("rd2_rd_addr", 256'(last_rd_addr), 256'(16'h0020));
    check("rd2_rd_pulses", 256'(rd_en_cnt), 256'(1));

    // Unsupported-length read -> UR completion without a register access
    clear_beats();
    rd_en0 = rd_en_cnt;
    tick();
    cq_req(4'b0000, 16'h0030, 64'h0, 3'd0, 16'h0001, 8'h21, 3'd1, 7'h08, 11'd4);
    wait_beats(1, 50, "ur_wait");
    check("ur_tdata", beat_data[0], {160'h0, 32'h0200_0021, 32'h0001_0800, 32'h0004_0008});
    check("ur_tkeep", 256'(beat_keep[0]), 256'(8'h07));
    check("ur_no_rd", 256'(rd_en_cnt), 256'(rd_en0));
    check("ur_unsup", 256'(unsupported_cnt), 256'(4));

    // Overflow: a stalled completion keeps the FIFO from draining
    clear_beats();
    rd_lat = 1;
    s_axis_cc_tready = 1'b0;
    tick();
    cq_req(4'b0000, 16'h003C, 64'h0, 3'd0, 16'h1234, 8'h0F, 3'd0, 7'h3C, 11'd1);
    repeat (10) @(negedge user_clk);
    check("ovf_stall_tvalid", 256'(s_axis_cc_tvalid), 256'(1));
    check("ovf_stall_tdata", s_axis_cc_tdata,
          {128'h0, 32'h5EED_003C, 32'h0000_000F, 32'h1234_0001, 32'h0004_003C});
    check("ovf_stall_tkeep", 256'(s_axis_cc_tkeep), 256'(8'h0F));
    tick();
    for (int i = 0; i < 5; i++)
      cq_req(4'b0000, 16'h0040 + 16'(4 * i), 64'h0, 3'd0, 16'h1234, 8'h10 + 8'(i), 3'd0,
             7'h40 + 7'(4 * i), 11'd1);
    @(negedge user_clk);
    check("ovf_flag", 256'(rd_overflow), 256'(1));
    check("ovf_hold_tdata", s_axis_cc_tdata,
          {128'h0, 32'h5EED_003C, 32'h0000_000F, 32'h1234_0001, 32'h0004_003C});
    // one handshake, then a read that lands while the full FIFO pops
    tick();
    s_axis_cc_tready = 1'b1;
    tick();
    s_axis_cc_tready = 1'b0;
    cq_req(4'b0000, 16'h0058, 64'h0, 3'd0, 16'h1234, 8'h15, 3'd0, 7'h58, 11'd1);
    s_axis_cc_tready = 1'b1;
    wait_beats(6, 200, "ovf_wait");
    exp_tags = '{8'h0F, 8'h10, 8'h11, 8'h12, 8'h13, 8'h15};
    exp_addr = '{16'h003C, 16'h0040, 16'h0044, 16'h0048, 16'h004C, 16'h0058};
    for (int i = 0; i < 6; i++) begin
      b = beat_data[i];
      check($sformatf("ovf_tag%0d", i), 256'(b[71:64]), 256'(exp_tags[i]));
      check($sformatf("ovf_dw0_%0d", i), 256'(b[127:96]), 256'({16'h5EED, exp_addr[i]}));
    end
    repeat (5) @(negedge user_clk);
    check("ovf_beats", 256'(beat_data.size()), 256'(6));
    check("idle_gap", 256'(b2b_cnt), 256'(0));

    // Read that never returns data -> all-ones payload after the timeout
    clear_beats();
    rd_resp_en = 1'b0;
    tick();
    cq_req(4'b0000, 16'h0050, 64'h0, 3'd0, 16'h0002, 8'h33, 3'd0, 7'h50, 11'd2);
    wait_beats(1, 400, "to_wait");
    check("to_tdata", beat_data[0],
          {96'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0033, 32'h0002_0002, 32'h0008_0050});
    check("to_tkeep", 256'(beat_keep[0]), 256'(8'h1F));
    check("to_delay", 256'((beat_cyc[0] - rd_en_cyc >= 255) && (beat_cyc[0] - rd_en_cyc <= 257)),
          256'(1));

    // Reset while a completion is stalled and further reads are queued
    clear_beats();
    rd_resp_en = 1'b1;
    s_axis_cc_tready = 1'b0;
    tick();
    cq_req(4'b0000, 16'h0060, 64'h0, 3'd0, 16'h0003, 8'h44, 3'd0, 7'h60, 11'd1);
    cq_req(4'b0000, 16'h0064, 64'h0, 3'd0, 16'h0003, 8'h45, 3'd0, 7'h64, 11'd1);
    cq_req(4'b0000, 16'h0068, 64'h0, 3'd0, 16'h0003, 8'h46, 3'd0, 7'h68, 11'd1);
    k = 0;
    while (!s_axis_cc_tvalid && k < 30) begin
      @(negedge user_clk);
      k++;
    end
    check("rst_mid_tvalid_pre", 256'(s_axis_cc_tvalid), 256'(1));
    @(negedge user_clk);
    #2 user_reset_n = 1'b0;
    #1;
    check("rst_mid_tvalid", 256'(s_axis_cc_tvalid), 256'(0));
    check("rst_mid_ovf", 256'(rd_overflow), 256'(0));
    check("rst_mid_unsup", 256'(unsupported_cnt), 256'(0));
    tick();
    user_reset_n = 1'b1;
    clear_beats();
    rd_en0 = rd_en_cnt;
    s_axis_cc_tready = 1'b1;
    repeat (30) @(negedge user_clk);
    check("rst_fifo_empty", 256'(beat_data.size()), 256'(0));
    check("rst_no_rd", 256'(rd_en_cnt), 256'(rd_en0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
